multicycle_control: RTL
=======================

# multicycle_control

Main controller for the multicycle MIPS core. It sequences a shared-memory datapath: IR, A/B, ALUOut and data registers, with one memory port for both instructions and data. It decodes opcode/funct into per-cycle datapath enables and mux selects, and stalls on a ready/request memory handshake. It also counts retired instructions for the performance and verification hooks.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  instruction[31:26] from IR
- funct  in  6  instruction[5:0] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  write strobe, valid with mem_req
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR (and MDR) from read data
- pc_en  out  1  load PC
- reg_write  out  1  register file write
- regdst  out  1  write-register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode
- instr_retired  out  CNT_W  retired-instruction count

## Operation
- One clock and one state register. Reset is asynchronous, active-high, and puts the FSM in FETCH with instr_retired = 0.
- Outputs are combinational from the state, plus mem_ready/zero gating where noted. Any output not listed for a state is 0.
- FETCH
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=add, pc_src=00.
  - ir_write and pc_en are asserted only when mem_ready=1.
  - The state holds until mem_ready, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode:
  - 100011 lw / 101011 sw → MEMADR
  - 000000 R-type → EXECUTE
  - 000100 beq → BRANCH
  - 001000 addi → ADDIEXEC
  - 000010 j → JUMP
  - any other opcode → FETCH, with illegal=1 (treated as a nop and counted as retired)
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready, then MEMWB.
- MEMWB: reg_write=1, regdst=0, mem_to_reg=1 → FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Holds until mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct → ALUWB.
  - funct 100000 → add, 100010 → sub, 100100 → and, 100101 → or, 101010 → slt.
  - Any other funct → add.
- ALUWB: reg_write=1, regdst=1, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero → FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, add → ADDIWB.
- ADDIWB: reg_write=1, regdst=0, mem_to_reg=0 → FETCH.
- JUMP: pc_src=10, pc_en=1 → FETCH.
- instr_retired increments by 1 on every clock edge where the next state is FETCH and the current state is not FETCH. It wraps modulo 2^CNT_W.

## Timing
- Cycle counts with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle mem_ready is low in FETCH/MEMRD/MEMWR adds exactly one cycle.
- The request/ready handshake:
  - mem_req stays asserted, with stable iord and mem_write, until the cycle mem_ready=1 is sampled.
  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- ir_write and pc_en in FETCH coincide with the mem_ready cycle; they never fire on a stalled cycle.
- Reset asserted mid-instruction: the FSM returns to FETCH immediately (asynchronously) and the counter clears.
- While reset is high, ir_write, pc_en, reg_write, mem_write, mem_req and illegal are forced to 0.
- The first mem_req appears in the first cycle after reset deasserts.
- Counter wrap: all-ones + 1 → 0, with no flag.

## Structure
- Package mips_ctrl_pkg holds:
  - the state_t enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP)
  - opcode and funct localparams
  - the alu_control codes
  - the alu_src_b and pc_src encodings
- Sub-module alu_decoder: combinational mapping of (aluop[1:0], funct) → alu_control.
  - aluop 00 = add, 01 = sub, 10 = funct.
  - Instantiated once inside multicycle_control.

## Test plan
- Reset, then lw (opcode 100011) with mem_ready always 1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 with mem_to_reg=1 in cycle 5; instr_retired=1.
- Instruction sequence with mem_ready held low for 3 cycles in FETCH:
  - sw → 7 cycles total, mem_write=1 only in MEMWR, no ir_write until ready.
  - R-type funct 101010 → alu_control=111 in EXECUTE.
- beq with zero=1 → pc_en=1, pc_src=01 in BRANCH; with zero=0 → pc_en=0. Both take 3 cycles.
- j → pc_src=10, pc_en=1 in cycle 3. Opcode 111111 → illegal pulse in DECODE, back to FETCH; counter increments.
- Reset pulsed during MEMRD with a stalled read → mem_req drops immediately; FSM in FETCH; instr_retired=0.
- CNT_W=4, run 16 addi → instr_retired wraps to 0. Each addi takes 4 cycles with reg_write=1, regdst=0 in ADDIWB.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// mips_ctrl_pkg: shared types and encodings for the multicycle MIPS controller.
//   state_t      - controller FSM states
//   OP_* / FN_*  - opcode and funct field values the controller decodes
//   ALU_*        - alu_control codes driven to the datapath ALU
//   ALUOP_*      - internal class code handed to alu_decoder
//   SRCB_* / PCSRC_* - alu_src_b and pc_src mux encodings
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: request/ready handshake to the shared memory port.
//   mem_req   - access request (controller -> memory)
//   mem_write - write strobe, valid with mem_req
//   iord      - address select: 0 = PC, 1 = ALUOut
//   mem_ready - memory completes the current access this cycle
// master: the controller; slave: the memory side.
interface multicycle_control_if;
  logic mem_req;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_write, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// alu_decoder: maps the controller's ALU class (aluop) and the R-type funct
// field to the datapath alu_control code.
//   aluop       in  2  00 = add, 01 = sub, 10 = decode funct
//   funct       in  6  instruction[5:0]
//   alu_control out 3  ALU operation code
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM of the multicycle MIPS core. Sequences the
// shared-memory datapath, stalls on the memory handshake and counts retired
// instructions.
//   clk, reset    - clock (rising edge), async active-high reset
//   opcode, funct - IR fields
//   zero          - ALU zero flag (beq decision)
//   mem           - memory handshake (master side)
//   ir_write .. alu_control - datapath enables and mux selects
//   illegal       - one-cycle pulse in DECODE for an unsupported opcode
//   instr_retired - wrapping retired-instruction count
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  multicycle_control_if.master mem,
  output logic                 ir_write,
  output logic                 pc_en,
  output logic                 reg_write,
  output logic                 regdst,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_src,
  output logic [2:0]           alu_control,
  output logic                 illegal,
  output logic [CNT_W-1:0]     instr_retired
);

  state_t     state, state_n;
  logic       req_c, wr_c, irw_c, pcen_c, rw_c, ill_c;
  logic       alu_used;
  logic [1:0] aluop;
  logic [2:0] dec_alu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FETCH;
      instr_retired <= '0;
    end else begin
      state <= state_n;
      // Retirement is the return to FETCH from any other state.
      if (state_n == FETCH && state != FETCH)
        instr_retired <= instr_retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_n    = state;
    req_c      = 1'b0;
    wr_c       = 1'b0;
    mem.iord   = 1'b0;
    irw_c      = 1'b0;
    pcen_c     = 1'b0;
    rw_c       = 1'b0;
    regdst     = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PCSRC_ALU;
    ill_c      = 1'b0;
    alu_used   = 1'b0;
    aluop      = ALUOP_ADD;
    case (state)
      FETCH: begin
        req_c     = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_used  = 1'b1;
        irw_c     = mem.mem_ready;
        pcen_c    = mem.mem_ready;
        if (mem.mem_ready) state_n = DECODE;
      end
      DECODE: begin
        alu_src_b = SRCB_IMMSH;
        alu_used  = 1'b1;
        case (opcode)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_RTYPE:     state_n = EXECUTE;
          OP_BEQ:       state_n = BRANCH;
          OP_ADDI:      state_n = ADDIEXEC;
          OP_J:         state_n = JUMP;
          default: begin
            state_n = FETCH;
            ill_c   = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_used  = 1'b1;
        state_n   = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        req_c    = 1'b1;
        mem.iord = 1'b1;
        if (mem.mem_ready) state_n = MEMWB;
      end
      MEMWB: begin
        rw_c       = 1'b1;
        mem_to_reg = 1'b1;
        state_n    = FETCH;
      end
      MEMWR: begin
        req_c    = 1'b1;
        wr_c     = 1'b1;
        mem.iord = 1'b1;
        if (mem.mem_ready) state_n = FETCH;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_used  = 1'b1;
        aluop     = ALUOP_FUNCT;
        state_n   = ALUWB;
      end
      ALUWB: begin
        rw_c    = 1'b1;
        regdst  = 1'b1;
        state_n = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_used  = 1'b1;
        aluop     = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        pcen_c    = zero;
        state_n   = FETCH;
      end
      ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_used  = 1'b1;
        state_n   = ADDIWB;
      end
      ADDIWB: begin
        rw_c    = 1'b1;
        state_n = FETCH;
      end
      JUMP: begin
        pc_src  = PCSRC_JUMP;
        pcen_c  = 1'b1;
        state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct       (funct),
    .alu_control (dec_alu)
  );

  // States that do not drive the ALU present alu_control = 000.
  assign alu_control = alu_used ? dec_alu : 3'b000;

  // Reset sits the FSM in FETCH; these strobes must still stay quiet.
  assign mem.mem_req   = req_c  & ~reset;
  assign mem.mem_write = wr_c   & ~reset;
  assign ir_write      = irw_c  & ~reset;
  assign pc_en         = pcen_c & ~reset;
  assign reg_write     = rw_c   & ~reset;
  assign illegal       = ill_c  & ~reset;

endmodule
